// File: rtl/rs_lat_ctrl.sv
// rs_lat_ctrl: excitation/sampling controller for an rs_lat entropy cell.
// Ports: clk, rst_n (async low); en run request; lat_rst/lat_r/lat_s drive
// the latch; lat_out comes back unsynchronized; rnd_data/rnd_valid/rnd_ready
// form the word handshake; busy = not idle; stuck = sticky all-0/all-1 word.
module rs_lat_ctrl #(
    parameter int WORD_W     = 8,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              lat_rst,
    output logic              lat_r,
    output logic              lat_s,
    input  logic              lat_out,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              stuck
);

    localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = $clog2(WORD_W);

    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, EXCITE, SETTLE, SAMPLE, OUTPUT
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic [WORD_W-1:0] shreg, shreg_d;
    logic [WORD_W-1:0] data_d;
    logic [WORD_W-1:0] shifted;
    logic              stuck_d;
    logic              sync1, sync_q;

    assign shifted = {shreg[WORD_W-2:0], sync_q};

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        data_d    = rnd_data;
        stuck_d   = stuck;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                state_d = EXCITE;
                cnt_d   = '0;
            end
            EXCITE: begin
                if (cnt == P_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == S_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                shreg_d = shifted;
                if (bit_cnt == B_LAST) begin
                    state_d   = OUTPUT;
                    bit_cnt_d = '0;
                    data_d    = shifted;
                    if (shifted == '0 || shifted == '1)
                        stuck_d = 1'b1;
                end else begin
                    state_d   = CLEAR;
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            OUTPUT: begin
                // en only matters once the held word has been taken
                if (rnd_ready)
                    state_d = en ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Losing en mid-word throws the partial word away
        if (!en && state inside {CLEAR, EXCITE, SETTLE, SAMPLE}) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = shreg;
            data_d    = rnd_data;
            stuck_d   = stuck;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            sync1     <= 1'b0;
            sync_q    <= 1'b0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            stuck     <= 1'b0;
            lat_rst   <= 1'b1;
            lat_r     <= 1'b0;
            lat_s     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            sync1     <= lat_out;
            sync_q    <= sync1;
            rnd_data  <= data_d;
            stuck     <= stuck_d;
            // Moore outputs registered from the next state
            rnd_valid <= (state_d == OUTPUT);
            busy      <= (state_d != IDLE);
            lat_rst   <= (state_d inside {IDLE, CLEAR, OUTPUT});
            lat_r     <= (state_d == EXCITE);
            lat_s     <= (state_d == EXCITE);
        end
    end

endmodule

// File: tb/tb_rs_lat_ctrl.sv
// tb_rs_lat_ctrl: directed bench for rs_lat_ctrl with a scripted latch model
// and a queue of expected words checked at each handshake.
module tb_rs_lat_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       lat_rst;
    logic       lat_r;
    logic       lat_s;
    logic       lat_out;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       busy;
    logic       stuck;

    int tests = 0;
    int fails = 0;

    bit         bitq[$];
    logic [7:0] expq[$];
    logic       model_bit = 1'b0;
    logic       prev_r = 1'b0;

    rs_lat_ctrl #(.WORD_W(8), .PULSE_CYC(4), .SETTLE_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .lat_rst   (lat_rst),
        .lat_r     (lat_r),
        .lat_s     (lat_s),
        .lat_out   (lat_out),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy),
        .stuck     (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch model: cleared -> 0, forbidden r=s=1 -> 1, released -> next scripted bit
    assign lat_out = lat_rst ? 1'b0 : ((lat_r & lat_s) ? 1'b1 : model_bit);

    always @(posedge clk) begin
        #1;
        if (rst_n && prev_r && !lat_r && !lat_rst) begin
            if (bitq.size() > 0)
                model_bit = bitq.pop_front();
        end
        prev_r = lat_r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--)
            bitq.push_back(w[i]);
        expq.push_back(w);
    endtask

    // Waits for a word (caller already passed the IDLE->CLEAR edge),
    // optionally holds ready low, then accepts it and drops en.
    task automatic get_word(input string tag, input int lat_exp, input int hold);
        int         n;
        bit         ok;
        logic [7:0] d0;
        logic [7:0] exp;
        n = 0;
        while (!rnd_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, rnd_valid, 1);
        if (lat_exp > 0)
            check({tag, "_latency"}, n, lat_exp);
        d0 = rnd_data;
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (!(rnd_valid && rnd_data === d0 && !lat_r && !lat_s && lat_rst))
                ok = 1'b0;
        end
        if (hold > 0)
            check({tag, "_hold_stable"}, ok, 1);
        en = 1'b0;
        rnd_ready = 1'b1;
        exp = (expq.size() > 0) ? expq.pop_front() : 8'h00;
        check({tag, "_data"}, rnd_data, exp);
        tick();
        check({tag, "_valid_drop"}, rnd_valid, 0);
        check({tag, "_idle"}, busy, 0);
        rnd_ready = 1'b0;
    endtask

    initial begin
        bit saw_valid;
        rst_n = 1'b0;
        en = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) tick();

        check("rst_lat_rst", lat_rst, 1);
        check("rst_lat_r", lat_r, 0);
        check("rst_lat_s", lat_s, 0);
        check("rst_data", rnd_data, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stuck", stuck, 0);

        rst_n = 1'b1;
        repeat (2) tick();

        // Plain word, ready held high
        push_word(8'hB2);
        rnd_ready = 1'b1;
        en = 1'b1;
        tick();
        check("w1_busy", busy, 1);
        get_word("w1", 80, 0);
        check("w1_stuck", stuck, 0);

        // Back-pressure for 20 cycles
        push_word(8'h4D);
        en = 1'b1;
        tick();
        get_word("w2", 80, 20);

        // Abort during EXCITE of the fourth bit
        bitq.push_back(1'b1);
        bitq.push_back(1'b1);
        bitq.push_back(1'b1);
        en = 1'b1;
        tick();
        repeat (32) tick();
        check("ab_excite_r", lat_r, 1);
        en = 1'b0;
        tick();
        check("ab_lat_r", lat_r, 0);
        check("ab_lat_rst", lat_rst, 1);
        check("ab_busy", busy, 0);
        saw_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (rnd_valid)
                saw_valid = 1'b1;
        end
        check("ab_no_valid", saw_valid, 0);
        bitq.delete();
        push_word(8'h3C);
        en = 1'b1;
        tick();
        get_word("w3", 80, 0);
        check("w3_stuck", stuck, 0);

        // All-ones word sets stuck, which then sticks
        push_word(8'hFF);
        en = 1'b1;
        tick();
        get_word("w4", 80, 0);
        check("w4_stuck", stuck, 1);
        push_word(8'h5A);
        en = 1'b1;
        tick();
        get_word("w5", 80, 0);
        check("w5_stuck_kept", stuck, 1);

        // Reset in the middle of SETTLE
        push_word(8'h96);
        en = 1'b1;
        tick();
        repeat (6) tick();
        check("rs_in_settle", {lat_rst, lat_r, busy}, 3'b001);
        rst_n = 1'b0;
        #2;
        check("rs_lat_rst", lat_rst, 1);
        check("rs_lat_r", lat_r, 0);
        check("rs_busy", busy, 0);
        check("rs_valid", rnd_valid, 0);
        check("rs_data", rnd_data, 0);
        check("rs_stuck", stuck, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        bitq.delete();
        expq.delete();
        tick();
        push_word(8'h96);
        en = 1'b1;
        tick();
        get_word("w6", 80, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
